l2_instruction_responder: RTL

L2_INSTRUCTION_RESPONDER -- requirements
Module: l2_instruction_responder

---
 rtl/l2_ins_pkg.sv | 23 ++
 rtl/l2_beat_assembler.sv | 29 ++
 rtl/l2_instruction_responder.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/l2_ins_pkg.sv
// Shared types and geometry for the L2 instruction responder.
// Geometry constants follow the default 32-bit word / 16-word block build.
package l2_ins_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SEND  = 2'd2
  } l2_state_e;

  localparam int DEF_DATA_WIDTH     = 32;
  localparam int DEF_WORD_PER_BLOCK = 16;

  localparam int WORDS_PER_BEAT =
    (DEF_WORD_PER_BLOCK * 8) / DEF_DATA_WIDTH;
  localparam int BEATS_PER_BLOCK =
    DEF_WORD_PER_BLOCK / WORDS_PER_BEAT;

  localparam int WORD_CNT_W = $clog2(WORDS_PER_BEAT);
  localparam int BEAT_CNT_W = $clog2(BEATS_PER_BLOCK);
  localparam int BLK_OFF_W  = WORD_CNT_W + BEAT_CNT_W;

endpackage

// File: rtl/l2_beat_assembler.sv
// Word-slot register file that gathers one beat of memory words
// into a single L2 bus-wide vector.
module l2_beat_assembler
  import l2_ins_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [WORDS_PER_BEAT-1:0]            i_we,
  input  logic [DATA_WIDTH-1:0]                i_wdata,
  output logic [WORDS_PER_BEAT*DATA_WIDTH-1:0] o_beat
);

  for (genvar k = 0; k < WORDS_PER_BEAT; k++) begin : g_slot
    logic [DATA_WIDTH-1:0] r_word;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_word <= '0;
      end else if (i_we[k]) begin
        r_word <= i_wdata;
      end
    end

    assign o_beat[DATA_WIDTH*k +: DATA_WIDTH] = r_word;
  end

endmodule

// File: rtl/l2_instruction_responder.sv
// L2 instruction responder: fetches a block word-by-word and returns it in beats.
// Define L2_INS_CRITICAL_BEAT_FIRST_EN to start with the beat holding the requested word.
module l2_instruction_responder
  import l2_ins_pkg::*;
#(
  parameter int ADDRESS_WIDTH  = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int WORD_PER_BLOCK = 16
) (
  input  logic                        CLK,
  input  logic                        RST_N,
  input  logic                        ADDRESS_TO_L2_VALID_INS,
  output logic                        ADDRESS_TO_L2_READY_INS,
  input  logic [ADDRESS_WIDTH-3:0]    ADDRESS_TO_L2_INS,
  output logic                        DATA_FROM_L2_VALID_INS,
  input  logic                        DATA_FROM_L2_READY_INS,
  output logic [WORD_PER_BLOCK*8-1:0] DATA_FROM_L2_INS,
  output logic                        MEM_REQ_VALID,
  input  logic                        MEM_REQ_READY,
  output logic [ADDRESS_WIDTH-3:0]    MEM_ADDRESS,
  input  logic                        MEM_RSP_VALID,
  input  logic [DATA_WIDTH-1:0]       MEM_RSP_DATA
);

  localparam int AW           = ADDRESS_WIDTH - 2;
  localparam int L2_BUS_WIDTH = WORD_PER_BLOCK * 8;
  localparam int BLK_W        = AW - BLK_OFF_W;

  l2_state_e               r_state;
  l2_state_e               w_state_nxt;
  logic [BLK_W-1:0]        r_blk;
  logic [BLK_W-1:0]        w_blk_nxt;
  logic [BEAT_CNT_W-1:0]   r_beat;
  logic [BEAT_CNT_W-1:0]   w_beat_nxt;
  logic [BEAT_CNT_W-1:0]   r_sent;
  logic [BEAT_CNT_W-1:0]   w_sent_nxt;
  logic [WORD_CNT_W-1:0]   r_word;
  logic [WORD_CNT_W-1:0]   w_word_nxt;
  logic                    r_pend;
  logic                    w_pend_nxt;
  logic                    r_live;
  logic [BEAT_CNT_W-1:0]   w_start_beat;
  logic [WORDS_PER_BEAT-1:0] w_we;
  logic [WORDS_PER_BEAT*DATA_WIDTH-1:0] w_beat_data;
  logic                    w_unused;

`ifdef L2_INS_CRITICAL_BEAT_FIRST_EN
  assign w_start_beat = ADDRESS_TO_L2_INS[WORD_CNT_W +: BEAT_CNT_W];
`else
  assign w_start_beat = '0;
`endif

  assign w_unused = ^ADDRESS_TO_L2_INS[BLK_OFF_W-1:0];

  // Block base is kept separately so the offset never carries out.
  assign MEM_ADDRESS      = {r_blk, r_beat, r_word};
  assign DATA_FROM_L2_INS = L2_BUS_WIDTH'(w_beat_data);

  always_comb begin
    w_state_nxt             = r_state;
    w_blk_nxt               = r_blk;
    w_beat_nxt              = r_beat;
    w_sent_nxt              = r_sent;
    w_word_nxt              = r_word;
    w_pend_nxt              = r_pend;
    w_we                    = '0;
    ADDRESS_TO_L2_READY_INS = 1'b0;
    DATA_FROM_L2_VALID_INS  = 1'b0;
    MEM_REQ_VALID           = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        ADDRESS_TO_L2_READY_INS = r_live;
        if (r_live && ADDRESS_TO_L2_VALID_INS) begin
          w_blk_nxt   = ADDRESS_TO_L2_INS[AW-1:BLK_OFF_W];
          w_beat_nxt  = w_start_beat;
          w_sent_nxt  = '0;
          w_word_nxt  = '0;
          w_pend_nxt  = 1'b0;
          w_state_nxt = ST_FETCH;
        end
      end
      ST_FETCH: begin
        MEM_REQ_VALID = !r_pend;
        if (!r_pend && MEM_REQ_READY) begin
          w_pend_nxt = 1'b1;
        end
        if (r_pend && MEM_RSP_VALID) begin
          w_pend_nxt   = 1'b0;
          w_we[r_word] = 1'b1;
          w_word_nxt   = r_word + 1'b1;
          if (r_word == WORD_CNT_W'(WORDS_PER_BEAT - 1)) begin
            w_state_nxt = ST_SEND;
          end
        end
      end
      ST_SEND: begin
        DATA_FROM_L2_VALID_INS = 1'b1;
        if (DATA_FROM_L2_READY_INS) begin
          w_word_nxt = '0;
          if (r_sent == BEAT_CNT_W'(BEATS_PER_BLOCK - 1)) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_sent_nxt  = r_sent + 1'b1;
            w_beat_nxt  = r_beat + 1'b1;
            w_state_nxt = ST_FETCH;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // r_live keeps the request port closed until the first edge after reset.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= ST_IDLE;
      r_blk   <= '0;
      r_beat  <= '0;
      r_sent  <= '0;
      r_word  <= '0;
      r_pend  <= 1'b0;
      r_live  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_blk   <= w_blk_nxt;
      r_beat  <= w_beat_nxt;
      r_sent  <= w_sent_nxt;
      r_word  <= w_word_nxt;
      r_pend  <= w_pend_nxt;
      r_live  <= 1'b1;
    end
  end

  l2_beat_assembler #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_beat_asm (
    .clk     (CLK),
    .rst_n   (RST_N),
    .i_we    (w_we),
    .i_wdata (MEM_RSP_DATA),
    .o_beat  (w_beat_data)
  );

endmodule
